byteperm_unit: RTL and testbench
================================

BYTEPERM_UNIT -- requirements
Module: byteperm_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand width; legal values are 32 and 64.
REQ-002 The block SHALL have parameter LANES, default 1, giving bytes processed per cycle; legal values are 1, 2, 4, 8, dividing WIDTH/8.
REQ-003 Port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1: asynchronous, active-high reset.
REQ-005 Port InValid, input, 1: operand and Op are valid this cycle.
REQ-006 Port InReady, output, 1: the unit accepts a new operation this cycle.
REQ-007 Port A, input, WIDTH: operand.
REQ-008 Port Op, input, 2: 00 rev8, 01 orc.b, 10 brev8, 11 brev (full bit reverse).
REQ-009 Port Flush, input, 1: synchronous abort of any in-flight or held operation.
REQ-010 Port OutValid, output, 1: Result is valid.
REQ-011 Port OutReady, input, 1: the consumer takes Result this cycle.
REQ-012 Port Result, output, WIDTH: operation result.

Function
REQ-013 Definitions: NB = WIDTH/8; STEPS = NB/LANES; byte i = bits [8i+7:8i].
REQ-014 The FSM SHALL have three states: IDLE, BUSY, DONE; InReady = (state==IDLE); OutValid = (state==DONE).
REQ-015 Accept: IDLE with InValid=1 and Flush=0 -> capture A and Op into internal registers, clear Result register, step counter=0, go BUSY; A/Op changes after accept SHALL NOT affect the result.
REQ-016 BUSY: each cycle SHALL process source bytes k*LANES..k*LANES+LANES-1 (k = step counter) and write the corresponding result bytes, then increment k; when k==STEPS-1 go DONE.
REQ-017 Latency: OutValid SHALL assert exactly STEPS cycles after the accepting edge (LANES=NB gives 1 cycle).
REQ-018 rev8: result byte NB-1-i = source byte i.
REQ-019 orc.b: result byte i = 0xFF if source byte i nonzero, else 0x00.
REQ-020 brev8: result byte i = source byte i with bit order reversed within the byte.
REQ-021 brev: result byte NB-1-i = bit-reversed source byte i (equals full WIDTH bit reversal).
REQ-022 DONE: Result and OutValid SHALL hold stable while OutReady=0; OutReady=1 -> IDLE next cycle; no accept in the same cycle as the handoff.
REQ-023 Result SHALL read zero whenever OutValid=0 (masked at the output).
REQ-024 Flush=1 in any state SHALL force IDLE on the next edge, discard the operation, and take priority over a simultaneous accept or handoff; OutValid SHALL not assert for the flushed operation.
REQ-025 InValid while InReady=0 SHALL be ignored (no queuing).
REQ-026 Illegal parameter combinations SHALL be rejected at elaboration.

Reset
REQ-027 reset=1 SHALL asynchronously force state IDLE, step counter 0, and internal operand, Op, and Result registers to 0; hence InReady=1, OutValid=0, Result=0.
REQ-028 reset asserted mid-operation SHALL abort it with no later OutValid; the first accept after deassertion SHALL behave normally.

Verification
REQ-029 WIDTH=32, LANES=1, rev8, A=0x12345678 -> OutValid 4 cycles after accept, Result=0x78563412; orc.b A=0x00FF0100 -> 0x00FFFF00.
REQ-030 WIDTH=32, LANES=2, brev8, A=0x01800F00 -> Result=0x8001F000 after 2 cycles; brev A=0x00000001 -> 0x80000000.
REQ-031 WIDTH=64, LANES=8, rev8, A=0x0123456789ABCDEF -> Result=0xEFCDAB8967452301 one cycle after accept.
REQ-032 Backpressure: OutReady=0 for 3 cycles in DONE -> Result and OutValid stable, InReady=0, InValid pulses ignored; OutReady=1 -> IDLE next cycle.
REQ-033 Flush at step 2 of a LANES=1, WIDTH=32 operation -> IDLE next cycle, no OutValid; the next op, rev8 of 0xAABBCCDD, gives 0xDDCCBBAA.
REQ-034 Reset asserted during BUSY and during DONE -> immediate InReady=1, OutValid=0, Result=0; the following operation is correct.

Source files
------------

// File: rtl/byteperm_unit.sv
`default_nettype none
// ============================================================================
//  Module      : byteperm_unit
//  Description : Multi-cycle byte permutation unit. Captures one operand and
//                operation, then builds the result LANES bytes per cycle:
//                rev8 (byte reverse), orc.b (byte OR-combine), brev8 (bit
//                reverse within bytes) and brev (full bit reverse).
//                Valid/ready handshake on both sides, synchronous flush.
//  Revision    : 1.0 - initial release
// ============================================================================
module byteperm_unit #(
    parameter int WIDTH = 32,
    parameter int LANES = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             InValid,
    output logic             InReady,
    input  logic [WIDTH-1:0] A,
    input  logic [1:0]       Op,
    input  logic             Flush,
    output logic             OutValid,
    input  logic             OutReady,
    output logic [WIDTH-1:0] Result
);

    // ------------------------------------------------------------------------
    // Derived constants
    // ------------------------------------------------------------------------
    localparam int c_NB    = WIDTH / 8;
    localparam int c_STEPS = (LANES > 0) ? (c_NB / LANES) : 1;
    localparam int c_CW    = (c_STEPS > 1) ? $clog2(c_STEPS) : 1;

    localparam logic [c_CW-1:0] c_LAST = c_CW'(c_STEPS - 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_BUSY = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    localparam logic [1:0] c_OP_REV8  = 2'b00;
    localparam logic [1:0] c_OP_ORCB  = 2'b01;
    localparam logic [1:0] c_OP_BREV8 = 2'b10;
    localparam logic [1:0] c_OP_BREV  = 2'b11;

    // ------------------------------------------------------------------------
    // Elaboration-time parameter legality check
    // ------------------------------------------------------------------------
    generate
        if (!((WIDTH == 32) || (WIDTH == 64)) ||
            !((LANES == 1) || (LANES == 2) || (LANES == 4) || (LANES == 8)) ||
            (LANES > (WIDTH / 8))) begin : g_bad_params
            $error("byteperm_unit: illegal WIDTH/LANES combination");
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Registers and wires
    // ------------------------------------------------------------------------
    logic [1:0]       r_state;
    logic [1:0]       w_next;
    logic [c_CW-1:0]  r_k;
    logic [WIDTH-1:0] r_a;
    logic [1:0]       r_op;
    logic [WIDTH-1:0] r_res;

    logic             w_accept;
    logic             w_reversed;
    logic [WIDTH-1:0] w_full;
    logic [c_NB-1:0]  w_src_win;
    logic [c_NB-1:0]  w_dst_win;
    logic [WIDTH-1:0] w_bitmask;

    // A new operation is taken only from IDLE; flush vetoes the accept.
    assign w_accept = (r_state == c_IDLE) && InValid && !Flush;

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next-state logic; flush overrides every other transition
    // ------------------------------------------------------------------------
    always_comb begin
        w_next = r_state;
        if (Flush) begin
            w_next = c_IDLE;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (InValid) begin
                        w_next = c_BUSY;
                    end
                end
                c_BUSY: begin
                    if (r_k == c_LAST) begin
                        w_next = c_DONE;
                    end
                end
                c_DONE: begin
                    if (OutReady) begin
                        w_next = c_IDLE;
                    end
                end
                default: w_next = c_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // FSM: outputs; the result is forced to zero whenever it is not valid
    // ------------------------------------------------------------------------
    always_comb begin
        InReady  = (r_state == c_IDLE);
        OutValid = (r_state == c_DONE);
        Result   = (r_state == c_DONE) ? r_res : '0;
    end

    // ------------------------------------------------------------------------
    // Full-width result of the captured operation, computed from the held
    // operand; only the bytes selected by the current step are committed.
    // ------------------------------------------------------------------------
    always_comb begin
        w_full = '0;
        case (r_op)
            c_OP_REV8: begin
                for (int i = 0; i < c_NB; i++) begin
                    w_full[8*(c_NB-1-i) +: 8] = r_a[8*i +: 8];
                end
            end
            c_OP_ORCB: begin
                for (int i = 0; i < c_NB; i++) begin
                    w_full[8*i +: 8] = {8{|r_a[8*i +: 8]}};
                end
            end
            c_OP_BREV8: begin
                for (int i = 0; i < c_NB; i++) begin
                    for (int b = 0; b < 8; b++) begin
                        w_full[8*i + b] = r_a[8*i + 7 - b];
                    end
                end
            end
            c_OP_BREV: begin
                for (int j = 0; j < WIDTH; j++) begin
                    w_full[j] = r_a[WIDTH-1-j];
                end
            end
            default: w_full = '0;
        endcase
    end

    // ------------------------------------------------------------------------
    // Source bytes handled this step: k*LANES .. k*LANES+LANES-1
    // ------------------------------------------------------------------------
    always_comb begin
        w_src_win = '0;
        for (int i = 0; i < c_NB; i++) begin
            w_src_win[i] = (r_k == c_CW'(i / LANES));
        end
    end

    // ------------------------------------------------------------------------
    // Map the source window onto destination bytes; rev8 and brev move byte i
    // to byte NB-1-i, the other ops keep bytes in place.
    // ------------------------------------------------------------------------
    always_comb begin
        w_reversed = (r_op == c_OP_REV8) || (r_op == c_OP_BREV);
        w_dst_win  = '0;
        w_bitmask  = '0;
        for (int d = 0; d < c_NB; d++) begin
            w_dst_win[d] = w_reversed ? w_src_win[c_NB-1-d] : w_src_win[d];
        end
        for (int d = 0; d < c_NB; d++) begin
            w_bitmask[8*d +: 8] = {8{w_dst_win[d]}};
        end
    end

    // ------------------------------------------------------------------------
    // Datapath: capture on accept, merge one window of result bytes per
    // BUSY cycle and advance the step counter.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_a   <= '0;
            r_op  <= '0;
            r_res <= '0;
            r_k   <= '0;
        end else if (w_accept) begin
            r_a   <= A;
            r_op  <= Op;
            r_res <= '0;
            r_k   <= '0;
        end else if ((r_state == c_BUSY) && !Flush) begin
            r_res <= (r_res & ~w_bitmask) | (w_full & w_bitmask);
            r_k   <= (r_k == c_LAST) ? '0 : (r_k + 1'b1);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_byteperm_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_byteperm_unit
//  Description : Self-checking bench for byteperm_unit. Three instances
//                (32/1, 32/2, 64/8) share stimulus; results are compared with
//                a behavioural model of the four byte operations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_byteperm_unit;

    logic        clk;
    logic        reset;
    logic        InValid;
    logic [63:0] A;
    logic [1:0]  Op;
    logic        Flush;
    logic        OutReady;

    logic [2:0]  rdy;
    logic [2:0]  vld;
    logic [31:0] res0;
    logic [31:0] res1;
    logic [63:0] res2;
    logic [63:0] resv [3];

    int checks;
    int errors;

    int c_NBS  [3] = '{4, 4, 8};
    int c_LATS [3] = '{4, 2, 1};

    assign resv[0] = {32'd0, res0};
    assign resv[1] = {32'd0, res1};
    assign resv[2] = res2;

    byteperm_unit #(.WIDTH(32), .LANES(1)) u_dut0 (
        .clk(clk), .reset(reset), .InValid(InValid), .InReady(rdy[0]),
        .A(A[31:0]), .Op(Op), .Flush(Flush), .OutValid(vld[0]),
        .OutReady(OutReady), .Result(res0)
    );

    byteperm_unit #(.WIDTH(32), .LANES(2)) u_dut1 (
        .clk(clk), .reset(reset), .InValid(InValid), .InReady(rdy[1]),
        .A(A[31:0]), .Op(Op), .Flush(Flush), .OutValid(vld[1]),
        .OutReady(OutReady), .Result(res1)
    );

    byteperm_unit #(.WIDTH(64), .LANES(8)) u_dut2 (
        .clk(clk), .reset(reset), .InValid(InValid), .InReady(rdy[2]),
        .A(A), .Op(Op), .Flush(Flush), .OutValid(vld[2]),
        .OutReady(OutReady), .Result(res2)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Reference: the four operations over an nb-byte operand
    function automatic logic [63:0] ref_model(input int nb, input logic [63:0] a,
                                              input logic [1:0] op);
        logic [63:0] r;
        logic [7:0]  s;
        r = '0;
        for (int i = 0; i < nb; i++) begin
            s = a[8*i +: 8];
            case (op)
                2'b00: r[8*(nb-1-i) +: 8] = s;
                2'b01: r[8*i +: 8] = (s != 8'h00) ? 8'hFF : 8'h00;
                2'b10: for (int b = 0; b < 8; b++) r[8*i + b] = s[7-b];
                default: for (int b = 0; b < 8; b++) r[8*(nb-1-i) + b] = s[7-b];
            endcase
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        for (int n = 0; n < 20 && rdy != 3'b111; n++) tick();
        check("ready", 64'(rdy), 64'h7);
    endtask

    task automatic start_op(input logic [63:0] a, input logic [1:0] op);
        wait_ready();
        A = a; Op = op; InValid = 1'b1;
        tick();
        InValid = 1'b0;
        A  = {$urandom, $urandom};
        Op = 2'($urandom_range(0, 3));
    endtask

    // One operation through all three instances with OutReady held high
    task automatic run_op(input logic [63:0] a, input logic [1:0] op);
        logic [63:0] exp [3];
        bit          seen [3];
        for (int d = 0; d < 3; d++) begin
            exp[d]  = ref_model(c_NBS[d], a, op);
            seen[d] = 1'b0;
        end
        OutReady = 1'b1;
        start_op(a, op);
        for (int c = 1; c <= 7; c++) begin
            tick();
            for (int d = 0; d < 3; d++) begin
                if (vld[d]) begin
                    if (!seen[d]) begin
                        check("latency", 64'(c), 64'(c_LATS[d]));
                        check("result", resv[d], exp[d]);
                        seen[d] = 1'b1;
                    end
                end else begin
                    check("masked", resv[d], 64'd0);
                end
            end
        end
        for (int d = 0; d < 3; d++) check("timeout", 64'(seen[d]), 64'd1);
    endtask

    initial begin
        logic [63:0] a;
        logic [63:0] exp [3];
        checks = 0; errors = 0;
        clk = 1'b0; reset = 1'b1; InValid = 1'b0; A = '0; Op = '0;
        Flush = 1'b0; OutReady = 1'b1;
        #1;
        check("reset_rdy", 64'(rdy), 64'h7);
        check("reset_vld", 64'(vld), 64'h0);
        check("reset_res", resv[0] | resv[1] | resv[2], 64'd0);
        tick(); tick();
        reset = 1'b0;
        tick();

        // Directed vectors
        run_op(64'h0000_0000_1234_5678, 2'b00);
        run_op(64'h0000_0000_00FF_0100, 2'b01);
        run_op(64'h0000_0000_0180_0F00, 2'b10);
        run_op(64'h0000_0000_0000_0001, 2'b11);
        run_op(64'h0123_4567_89AB_CDEF, 2'b00);

        // Backpressure: hold in DONE, ignore InValid, release
        for (int d = 0; d < 3; d++) exp[d] = ref_model(c_NBS[d], 64'hDEAD_BEEF_0F1E_2D3C, 2'b10);
        OutReady = 1'b0;
        start_op(64'hDEAD_BEEF_0F1E_2D3C, 2'b10);
        for (int n = 0; n < 10 && !vld[0]; n++) tick();
        check("bp_reach", 64'(vld), 64'h7);
        for (int n = 0; n < 3; n++) begin
            InValid = 1'b1; A = {$urandom, $urandom};
            tick();
            check("bp_vld", 64'(vld), 64'h7);
            check("bp_rdy", 64'(rdy), 64'h0);
            for (int d = 0; d < 3; d++) check("bp_res", resv[d], exp[d]);
        end
        InValid = 1'b0; OutReady = 1'b1;
        tick();
        check("bp_rel_rdy", 64'(rdy), 64'h7);
        check("bp_rel_vld", 64'(vld), 64'h0);
        tick();
        check("bp_no_queue", 64'(rdy), 64'h7);

        // Flush at step 2 of the LANES=1 instance
        start_op(64'h1111_2222_3333_4444, 2'b00);
        tick(); tick();
        Flush = 1'b1;
        tick();
        Flush = 1'b0;
        check("flush_rdy", 64'(rdy), 64'h7);
        check("flush_vld", 64'(vld), 64'h0);
        for (int n = 0; n < 6; n++) begin
            tick();
            check("flush_quiet", 64'(vld[0]), 64'd0);
        end
        run_op(64'h0000_0000_AABB_CCDD, 2'b00);

        // Reset during BUSY (instance 0)
        start_op(64'h0000_0000_5566_7788, 2'b11);
        tick(); tick();
        #2 reset = 1'b1;
        #1;
        check("rst_busy_rdy", 64'(rdy), 64'h7);
        check("rst_busy_vld", 64'(vld), 64'h0);
        check("rst_busy_res", resv[0] | resv[1] | resv[2], 64'd0);
        tick();
        reset = 1'b0;
        for (int n = 0; n < 6; n++) begin
            tick();
            check("rst_quiet", 64'(vld), 64'h0);
        end
        run_op(64'h0000_0000_0102_0304, 2'b10);

        // Reset during DONE
        OutReady = 1'b0;
        start_op(64'h0000_0000_C0DE_F00D, 2'b00);
        for (int n = 0; n < 10 && !vld[0]; n++) tick();
        check("done_reach", 64'(vld), 64'h7);
        #2 reset = 1'b1;
        #1;
        check("rst_done_rdy", 64'(rdy), 64'h7);
        check("rst_done_vld", 64'(vld), 64'h0);
        check("rst_done_res", resv[0] | resv[1] | resv[2], 64'd0);
        tick();
        reset = 1'b0;
        OutReady = 1'b1;
        tick();
        run_op(64'h0000_0000_1234_5678, 2'b00);

        // Randomized operations, with some zero bytes to exercise orc.b
        for (int t = 0; t < 40; t++) begin
            a = {$urandom, $urandom};
            for (int b = 0; b < 8; b++) begin
                if ($urandom_range(0, 3) == 0) a[8*b +: 8] = 8'h00;
            end
            run_op(a, 2'($urandom_range(0, 3)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
